wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage for the STRV32I pipeline.
- Accepts one retiring instruction per handshake from execute and selects the result source.
- Waits for, aligns and sign-/zero-extends load data, with a timeout.
- Drives a registered register-file write port and hazard/forwarding status, and counts retired instructions.
- Generalised in XLEN, load timeout and counter width.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
LD_TIMEOUT, 15, cycles spent in WAIT_LD without ld_valid_in before the load is dropped; must be at least 1
CNT_W, 64, width of the retired-instruction counter

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_in  input  1  synchronous reset, active-high
ex_valid_in  input  1  execute presents an instruction
ex_ready_out  output  1  stage can accept; combinational: state==IDLE and !rst_in
wb_mux_sel_in  input  3  source select: 000 alu, 001 load, 010 imm, 011 iadder, 100 csr, 101 pc+4, 110/111 alu
rf_wr_en_in  input  1  instruction writes rd
rd_addr_in  input  5  destination register
alu_result_in  input  XLEN  ALU result
imm_in  input  XLEN  immediate
iadder_in  input  XLEN  address adder result
csr_data_in  input  XLEN  CSR read data
pc_plus_4_in  input  XLEN  link value
ld_size_in  input  2  00 byte, 01 half, 10 word, 11 dword (treated as word when XLEN=32)
ld_unsigned_in  input  1  zero-extend when 1, sign-extend when 0
ld_addr_in  input  log2(XLEN/8)  byte offset within the data word
ld_data_in  input  XLEN  raw memory read data
ld_valid_in  input  1  ld_data_in valid this cycle
rf_wr_en_out  output  1  register-file write strobe, one-cycle pulse
rf_rd_addr_out  output  5  write address
rf_wr_data_out  output  XLEN  write data
fwd_pending_out  output  1  load outstanding; rd not yet available
fwd_pending_rd_out  output  5  rd of the outstanding load
ld_err_out  output  1  sticky; set on load timeout, cleared only by reset
instret_out  output  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_in high at an edge):
  - state=IDLE; every registered output = 0; timeout counter = 0; ld_err_out = 0; instret_out = 0.
  - ex_ready_out = 0 while rst_in is high.
  - An outstanding load is abandoned; no write occurs.
- States:
  - IDLE: ex_ready_out=1.
  - WAIT_LD: ex_ready_out=0; fwd_pending_out=1; fwd_pending_rd_out=captured rd.
- Accept rule: an instruction is accepted at an edge where ex_valid_in && ex_ready_out.
- Non-load accept (sel != 001):
  - At that edge: rf_wr_data_out <= selected source; rf_rd_addr_out <= rd_addr_in; rf_wr_en_out <= rf_wr_en_in && rd_addr_in!=0.
  - Write is visible the cycle after acceptance (latency 1).
  - instret increments.
- Load accept with ld_valid_in already high in the same cycle: completes as a non-load would, with aligned load data.
- Load accept with ld_valid_in low:
  - Capture rd, rf_wr_en, size, unsigned flag and offset.
  - Go to WAIT_LD and clear the timeout counter.
- WAIT_LD:
  - ld_valid_in high: write aligned data with latency 1, increment instret, go to IDLE.
  - ld_valid_in low: counter increments. When the counter reaches LD_TIMEOUT: set ld_err_out, no write, no instret increment, go to IDLE.
  - ld_valid_in and timeout in the same cycle: the load wins (write, no error).
- ex_valid_in while in WAIT_LD is not accepted (ex_ready_out=0); execute holds its inputs.
- Load alignment:
  - shifted = ld_data_in >> (8*ld_addr_in).
  - Take the low 8/16/32/64 bits per size.
  - Sign-extend from the field MSB unless ld_unsigned_in is set.
  - Misaligned accesses crossing the word boundary use zero-filled upper bits from the shift; no trap.
- rf_wr_en_out is 0 in every cycle without a completing write. rf_rd_addr_out and rf_wr_data_out hold their last values.
- rd=0: no write strobe, but the instruction still retires.
- instret_out increments by 1 per retirement and wraps at 2^CNT_W.
- Back-to-back non-loads: one accept per cycle, one write per cycle.

Test Plan:
- Reset, then ex_valid_in=1, sel=000, alu=0x1234, rd=5, rf_wr_en_in=1 -> next cycle rf_wr_en_out=1, rd=5, data=0x1234, instret=1; following cycle rf_wr_en_out=0.
- Load, sel=001, size=byte, signed, offset=2, ld_valid_in high 3 cycles after accept, ld_data=0x00A50000 -> ex_ready_out=0 and fwd_pending_out=1 for 3 cycles; then write 0xFFFFFFA5. Repeat unsigned -> 0x000000A5.
- Load with ld_valid_in never asserted, LD_TIMEOUT=15 -> after 15 WAIT_LD cycles ld_err_out=1, no write, instret unchanged, ex_ready_out=1 again.
- sel=101, pc+4=0x80000004, rd=0, rf_wr_en_in=1 -> rf_wr_en_out stays 0; instret increments.
- rst_in asserted during WAIT_LD -> no write; fwd_pending_out=0 and all outputs 0 after the edge; first accept after reset behaves normally.
- XLEN=64, CNT_W=4: dword load with offset 0 returns raw data; 16 retirements -> instret_out wraps to 0.

Source files
------------

// File: rtl/wb_stage_if.sv
// Execute-to-writeback bus: retiring instruction, load return data and
// register-file / hazard status driven back by the writeback stage.
interface wb_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
);
  localparam int unsigned OFF_W = $clog2(XLEN / 8);

  logic             ex_valid_in;
  logic             ex_ready_out;
  logic [2:0]       wb_mux_sel_in;
  logic             rf_wr_en_in;
  logic [4:0]       rd_addr_in;
  logic [XLEN-1:0]  alu_result_in;
  logic [XLEN-1:0]  imm_in;
  logic [XLEN-1:0]  iadder_in;
  logic [XLEN-1:0]  csr_data_in;
  logic [XLEN-1:0]  pc_plus_4_in;
  logic [1:0]       ld_size_in;
  logic             ld_unsigned_in;
  logic [OFF_W-1:0] ld_addr_in;
  logic [XLEN-1:0]  ld_data_in;
  logic             ld_valid_in;
  logic             rf_wr_en_out;
  logic [4:0]       rf_rd_addr_out;
  logic [XLEN-1:0]  rf_wr_data_out;
  logic             fwd_pending_out;
  logic [4:0]       fwd_pending_rd_out;
  logic             ld_err_out;
  logic [CNT_W-1:0] instret_out;

  modport slave (
    input  ex_valid_in, wb_mux_sel_in, rf_wr_en_in, rd_addr_in, alu_result_in,
           imm_in, iadder_in, csr_data_in, pc_plus_4_in, ld_size_in,
           ld_unsigned_in, ld_addr_in, ld_data_in, ld_valid_in,
    output ex_ready_out, rf_wr_en_out, rf_rd_addr_out, rf_wr_data_out,
           fwd_pending_out, fwd_pending_rd_out, ld_err_out, instret_out
  );

  modport master (
    output ex_valid_in, wb_mux_sel_in, rf_wr_en_in, rd_addr_in, alu_result_in,
           imm_in, iadder_in, csr_data_in, pc_plus_4_in, ld_size_in,
           ld_unsigned_in, ld_addr_in, ld_data_in, ld_valid_in,
    input  ex_ready_out, rf_wr_en_out, rf_rd_addr_out, rf_wr_data_out,
           fwd_pending_out, fwd_pending_rd_out, ld_err_out, instret_out
  );
endinterface

// File: rtl/wb_stage.sv
// STRV32I writeback stage: result select, load wait/align/extend with timeout,
// registered register-file write port, forwarding status and instret counter.
module wb_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned LD_TIMEOUT = 15,
  parameter int unsigned CNT_W      = 64
) (
  input  logic      clk_in,
  input  logic      rst_in,
  wb_stage_if.slave wb
);
  localparam int unsigned OFF_W  = $clog2(XLEN / 8);
  localparam int unsigned TCNT_W = $clog2(LD_TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT_LD} state_e;

  state_e           state_q, state_d;
  logic [4:0]       ld_rd_q, ld_rd_d;
  logic             ld_wen_q, ld_wen_d;
  logic [1:0]       ld_size_q, ld_size_d;
  logic             ld_uns_q, ld_uns_d;
  logic [OFF_W-1:0] ld_off_q, ld_off_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic             rf_wr_en_q, rf_wr_en_d;
  logic [4:0]       rf_rd_addr_q, rf_rd_addr_d;
  logic [XLEN-1:0]  rf_wr_data_q, rf_wr_data_d;
  logic             ld_err_q, ld_err_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [1:0]       al_size;
  logic             al_uns;
  logic [OFF_W-1:0] al_off;
  logic [XLEN-1:0]  shifted, field_top, ld_aligned, src_data;
  logic [6:0]       fld_w, pad;
  logic             accept;

  assign wb.ex_ready_out = (state_q == IDLE) && !rst_in;
  assign accept          = wb.ex_valid_in && wb.ex_ready_out;

  // Load alignment: in WAIT_LD the captured access attributes are used.
  always_comb begin
    al_size = (state_q == WAIT_LD) ? ld_size_q : wb.ld_size_in;
    al_uns  = (state_q == WAIT_LD) ? ld_uns_q  : wb.ld_unsigned_in;
    al_off  = (state_q == WAIT_LD) ? ld_off_q  : wb.ld_addr_in;
    shifted = wb.ld_data_in >> {al_off, 3'b000};
    case (al_size)
      2'd0:    fld_w = 7'd8;
      2'd1:    fld_w = 7'd16;
      2'd2:    fld_w = 7'd32;
      default: fld_w = (XLEN == 64) ? 7'd64 : 7'd32;
    endcase
    pad        = 7'(XLEN) - fld_w;
    // Field is moved to the top, then shifted back down to extend it.
    field_top  = shifted << pad;
    ld_aligned = al_uns ? (field_top >> pad) : XLEN'($signed(field_top) >>> pad);
  end

  always_comb begin
    case (wb.wb_mux_sel_in)
      3'b001:  src_data = ld_aligned;
      3'b010:  src_data = wb.imm_in;
      3'b011:  src_data = wb.iadder_in;
      3'b100:  src_data = wb.csr_data_in;
      3'b101:  src_data = wb.pc_plus_4_in;
      default: src_data = wb.alu_result_in;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ld_rd_d      = ld_rd_q;
    ld_wen_d     = ld_wen_q;
    ld_size_d    = ld_size_q;
    ld_uns_d     = ld_uns_q;
    ld_off_d     = ld_off_q;
    tcnt_d       = tcnt_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_addr_d = rf_rd_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    ld_err_d     = ld_err_q;
    instret_d    = instret_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (wb.wb_mux_sel_in == 3'b001 && !wb.ld_valid_in) begin
            ld_rd_d   = wb.rd_addr_in;
            ld_wen_d  = wb.rf_wr_en_in;
            ld_size_d = wb.ld_size_in;
            ld_uns_d  = wb.ld_unsigned_in;
            ld_off_d  = wb.ld_addr_in;
            tcnt_d    = '0;
            state_d   = WAIT_LD;
          end else begin
            rf_wr_data_d = src_data;
            rf_rd_addr_d = wb.rd_addr_in;
            rf_wr_en_d   = wb.rf_wr_en_in && (wb.rd_addr_in != 5'd0);
            instret_d    = instret_q + CNT_W'(1);
          end
        end
      end
      WAIT_LD: begin
        if (wb.ld_valid_in) begin
          rf_wr_data_d = ld_aligned;
          rf_rd_addr_d = ld_rd_q;
          rf_wr_en_d   = ld_wen_q && (ld_rd_q != 5'd0);
          instret_d    = instret_q + CNT_W'(1);
          state_d      = IDLE;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
          if (tcnt_d == TCNT_W'(LD_TIMEOUT)) begin
            ld_err_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      ld_rd_q      <= '0;
      ld_wen_q     <= 1'b0;
      ld_size_q    <= '0;
      ld_uns_q     <= 1'b0;
      ld_off_q     <= '0;
      tcnt_q       <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_addr_q <= '0;
      rf_wr_data_q <= '0;
      ld_err_q     <= 1'b0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      ld_rd_q      <= ld_rd_d;
      ld_wen_q     <= ld_wen_d;
      ld_size_q    <= ld_size_d;
      ld_uns_q     <= ld_uns_d;
      ld_off_q     <= ld_off_d;
      tcnt_q       <= tcnt_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      ld_err_q     <= ld_err_d;
      instret_q    <= instret_d;
    end
  end

  assign wb.rf_wr_en_out       = rf_wr_en_q;
  assign wb.rf_rd_addr_out     = rf_rd_addr_q;
  assign wb.rf_wr_data_out     = rf_wr_data_q;
  assign wb.fwd_pending_out    = (state_q == WAIT_LD);
  assign wb.fwd_pending_rd_out = ld_rd_q;
  assign wb.ld_err_out         = ld_err_q;
  assign wb.instret_out        = instret_q;
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a 32-bit and a 64-bit (CNT_W=4) instance share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(32), .CNT_W(64)) b32 ();
  wb_stage_if #(.XLEN(64), .CNT_W(4))  b64 ();

  wb_stage #(.XLEN(32), .LD_TIMEOUT(15), .CNT_W(64)) dut32 (.clk_in(clk), .rst_in(rst), .wb(b32.slave));
  wb_stage #(.XLEN(64), .LD_TIMEOUT(15), .CNT_W(4))  dut64 (.clk_in(clk), .rst_in(rst), .wb(b64.slave));

  // stimulus
  logic        v, wen, ldv, uns;
  logic [2:0]  sel, off;
  logic [4:0]  rd;
  logic [1:0]  size;
  logic [63:0] alu, imm, iad, csr, pc4, ldd;

  // model state
  bit          m_pend;
  int          m_wait;
  logic [4:0]  m_prd;
  bit          m_pwen, m_puns;
  logic [1:0]  m_psize;
  logic [2:0]  m_poff;
  bit          e_wen, e_err;
  logic [4:0]  e_rd;
  logic [63:0] e_d32, e_d64;
  longint unsigned m_ret;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic drive();
    b32.ex_valid_in = v;          b64.ex_valid_in = v;
    b32.wb_mux_sel_in = sel;      b64.wb_mux_sel_in = sel;
    b32.rf_wr_en_in = wen;        b64.rf_wr_en_in = wen;
    b32.rd_addr_in = rd;          b64.rd_addr_in = rd;
    b32.alu_result_in = alu[31:0]; b64.alu_result_in = alu;
    b32.imm_in = imm[31:0];       b64.imm_in = imm;
    b32.iadder_in = iad[31:0];    b64.iadder_in = iad;
    b32.csr_data_in = csr[31:0];  b64.csr_data_in = csr;
    b32.pc_plus_4_in = pc4[31:0]; b64.pc_plus_4_in = pc4;
    b32.ld_size_in = size;        b64.ld_size_in = size;
    b32.ld_unsigned_in = uns;     b64.ld_unsigned_in = uns;
    b32.ld_addr_in = off[1:0];    b64.ld_addr_in = off;
    b32.ld_data_in = ldd[31:0];   b64.ld_data_in = ldd;
    b32.ld_valid_in = ldv;        b64.ld_valid_in = ldv;
  endtask

  // Byte-wise gather of the loaded field, then extension, for an xb-byte datapath.
  function automatic logic [63:0] align(int xb, logic [63:0] d, logic [1:0] sz, bit u, int o);
    int nb;
    logic [63:0] r;
    nb = (sz == 2'd3) ? ((xb == 8) ? 8 : 4) : (1 << sz);
    r  = '0;
    for (int i = 0; i < nb; i++)
      if (o + i < xb) r[8*i +: 8] = d[8*(o+i) +: 8];
    if (!u && r[8*nb-1])
      for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
    if (xb == 4) r[63:32] = '0;
    return r;
  endfunction

  function automatic logic [63:0] pick(int xb, logic [63:0] ld_al);
    logic [63:0] r;
    case (sel)
      3'd1: r = ld_al;
      3'd2: r = imm;
      3'd3: r = iad;
      3'd4: r = csr;
      3'd5: r = pc4;
      default: r = alu;
    endcase
    if (xb == 4) r[63:32] = '0;
    return r;
  endfunction

  task automatic complete(input logic [4:0] r, input bit w, input logic [63:0] d32, input logic [63:0] d64);
    e_rd  = r;
    e_wen = w && (r != 5'd0);
    e_d32 = d32;
    e_d64 = d64;
    m_ret++;
  endtask

  task automatic model_step();
    if (rst) begin
      m_pend = 0; m_wait = 0; m_prd = '0;
      e_wen = 0; e_err = 0; e_rd = '0; e_d32 = '0; e_d64 = '0; m_ret = 0;
    end else begin
      e_wen = 0;
      if (m_pend) begin
        if (ldv) begin
          complete(m_prd, m_pwen, align(4, ldd, m_psize, m_puns, int'(m_poff[1:0])),
                   align(8, ldd, m_psize, m_puns, int'(m_poff)));
          m_pend = 0;
        end else begin
          m_wait++;
          if (m_wait == 15) begin
            e_err  = 1;
            m_pend = 0;
          end
        end
      end else if (v) begin
        if (sel == 3'd1 && !ldv) begin
          m_pend = 1; m_wait = 0; m_prd = rd; m_pwen = wen;
          m_psize = size; m_puns = uns; m_poff = off;
        end else begin
          complete(rd, wen, pick(4, align(4, ldd, size, uns, int'(off[1:0]))),
                   pick(8, align(8, ldd, size, uns, int'(off))));
        end
      end
    end
  endtask

  task automatic check_all();
    chk("ready32", 64'(b32.ex_ready_out), 64'(!m_pend && !rst));
    chk("wen32",   64'(b32.rf_wr_en_out), 64'(e_wen));
    chk("rd32",    64'(b32.rf_rd_addr_out), 64'(e_rd));
    chk("data32",  64'(b32.rf_wr_data_out), e_d32);
    chk("pend32",  64'(b32.fwd_pending_out), 64'(m_pend));
    if (m_pend) chk("pendrd32", 64'(b32.fwd_pending_rd_out), 64'(m_prd));
    chk("err32",   64'(b32.ld_err_out), 64'(e_err));
    chk("ret32",   b32.instret_out, m_ret);
    chk("ready64", 64'(b64.ex_ready_out), 64'(!m_pend && !rst));
    chk("wen64",   64'(b64.rf_wr_en_out), 64'(e_wen));
    chk("rd64",    64'(b64.rf_rd_addr_out), 64'(e_rd));
    chk("data64",  b64.rf_wr_data_out, e_d64);
    chk("pend64",  64'(b64.fwd_pending_out), 64'(m_pend));
    chk("err64",   64'(b64.ld_err_out), 64'(e_err));
    chk("ret64",   64'(b64.instret_out), 64'(m_ret[3:0]));
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    v = 0; wen = 0; ldv = 0; uns = 0; sel = '0; off = '0; rd = '0; size = '0; rst = 0;
    alu = '0; imm = '0; iad = '0; csr = '0; pc4 = '0; ldd = '0;
  endtask

  task automatic ld_req(input logic [4:0] r, input logic [1:0] sz, input bit u, input logic [2:0] o);
    idle(); v = 1; sel = 3'd1; wen = 1; rd = r; size = sz; uns = u; off = o;
  endtask

  initial begin
    int thr;
    idle();
    rst = 1;
    step();
    chk("rst_ready", 64'(b32.ex_ready_out), 64'd0);
    chk("rst_ret", b32.instret_out, 64'd0);

    // ALU write, latency 1, then strobe drops
    idle(); v = 1; sel = 3'd0; alu = 64'h1234; rd = 5'd5; wen = 1;
    step();
    chk("t1_wen", 64'(b32.rf_wr_en_out), 64'd1);
    chk("t1_rd", 64'(b32.rf_rd_addr_out), 64'd5);
    chk("t1_data", 64'(b32.rf_wr_data_out), 64'h1234);
    chk("t1_ret", b32.instret_out, 64'd1);
    idle(); step();
    chk("t1_wen_drop", 64'(b32.rf_wr_en_out), 64'd0);

    // signed then unsigned byte load, data 3 cycles after accept
    for (int k = 0; k < 2; k++) begin
      ld_req(5'd7, 2'd0, k[0], 3'd2);
      step();
      for (int c = 0; c < 3; c++) begin
        chk("ld_ready_lo", 64'(b32.ex_ready_out), 64'd0);
        chk("ld_pend", 64'(b32.fwd_pending_out), 64'd1);
        idle(); ldd = 64'h00A50000; ldv = (c == 2);
        step();
      end
      chk("ld_wen", 64'(b32.rf_wr_en_out), 64'd1);
      chk("ld_data32", 64'(b32.rf_wr_data_out), (k == 0) ? 64'hFFFFFFA5 : 64'hA5);
      chk("ld_data64", b64.rf_wr_data_out, (k == 0) ? 64'hFFFFFFFFFFFFFFA5 : 64'hA5);
    end

    // timeout: 15 WAIT_LD cycles with no data
    ld_req(5'd9, 2'd2, 1'b0, 3'd0);
    step();
    idle();
    for (int c = 0; c < 14; c++) step();
    chk("to_pend14", 64'(b32.fwd_pending_out), 64'd1);
    chk("to_err14", 64'(b32.ld_err_out), 64'd0);
    step();
    chk("to_err", 64'(b32.ld_err_out), 64'd1);
    chk("to_ready", 64'(b32.ex_ready_out), 64'd1);
    chk("to_wen", 64'(b32.rf_wr_en_out), 64'd0);
    chk("to_ret", b32.instret_out, 64'd3);

    // rd=0 link write: no strobe, still retires
    idle(); v = 1; sel = 3'd5; pc4 = 64'h80000004; rd = 5'd0; wen = 1;
    step();
    chk("rd0_wen", 64'(b32.rf_wr_en_out), 64'd0);
    chk("rd0_data", 64'(b32.rf_wr_data_out), 64'h80000004);
    chk("rd0_ret", b32.instret_out, 64'd4);

    // reset during WAIT_LD
    ld_req(5'd4, 2'd1, 1'b0, 3'd0);
    step();
    idle(); step();
    rst = 1; step();
    chk("rw_pend", 64'(b32.fwd_pending_out), 64'd0);
    chk("rw_wen", 64'(b32.rf_wr_en_out), 64'd0);
    chk("rw_err", 64'(b32.ld_err_out), 64'd0);
    chk("rw_ret", b32.instret_out, 64'd0);
    idle(); v = 1; alu = 64'h55; rd = 5'd3; wen = 1;
    step();
    chk("rw_first", 64'(b32.rf_wr_data_out), 64'h55);
    chk("rw_first_ret", b32.instret_out, 64'd1);

    // dword load, offset 0, data present at accept
    ld_req(5'd8, 2'd3, 1'b0, 3'd0); ldv = 1; ldd = 64'h0123456789ABCDEF;
    step();
    chk("dw_data64", b64.rf_wr_data_out, 64'h0123456789ABCDEF);
    chk("dw_data32", 64'(b32.rf_wr_data_out), 64'h89ABCDEF);

    // 16 retirements since reset wrap the 4-bit counter
    for (int c = 0; c < 14; c++) begin
      idle(); v = 1; alu = 64'(c); rd = 5'd1; wen = 1;
      step();
    end
    chk("wrap64", 64'(b64.instret_out), 64'd0);
    chk("wrap32", b32.instret_out, 64'd16);

    // randomized traffic with varying load-data latency
    for (int n = 0; n < 3000; n++) begin
      case (n / 750)
        0: thr = 2;
        1: thr = 4;
        2: thr = 16;
        default: thr = 64;
      endcase
      v    = ($urandom % 4) != 0;
      sel  = ($urandom % 3 == 0) ? 3'd1 : 3'($urandom);
      wen  = ($urandom % 8) != 0;
      rd   = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
      size = 2'($urandom);
      uns  = 1'($urandom);
      off  = 3'($urandom);
      alu  = {$urandom, $urandom}; imm = {$urandom, $urandom};
      iad  = {$urandom, $urandom}; csr = {$urandom, $urandom};
      pc4  = {$urandom, $urandom}; ldd = {$urandom, $urandom};
      ldv  = ($urandom % thr) == 0;
      rst  = ($urandom % 400) == 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
